// File: rtl/sw_pkg.sv
// Shared Smith-Waterman types and helpers: score format, nucleotide codes,
// collector result record and the offset-binary to two's-complement conversion.
package sw_pkg;

    localparam int SCORE_WIDTH = 11;
    localparam int LEN_WIDTH   = 16;
    localparam int ID_WIDTH    = 16;

    localparam logic [SCORE_WIDTH-1:0] NEUTRAL_SCORE = 11'h400;

    typedef enum logic [1:0] {
        N_A = 2'b00,
        N_G = 2'b01,
        N_T = 2'b10,
        N_C = 2'b11
    } nucleotide_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]           id;
        logic signed [SCORE_WIDTH-1:0] score;
        logic [LEN_WIDTH-1:0]          len;
        logic                          hit;
    } sw_result_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        COMMIT = 2'd2
    } coll_state_t;

    // Offset binary with neutral at 2^(W-1): flipping the MSB subtracts the bias.
    function automatic logic signed [SCORE_WIDTH-1:0] to_signed_score(
        input logic [SCORE_WIDTH-1:0] raw
    );
        return {~raw[SCORE_WIDTH-1], raw[SCORE_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/sw_result_fifo.sv
// First-word-fall-through FIFO for packed collector results; head reads as zero
// whenever empty so downstream never sees stale data.
module sw_result_fifo #(
    parameter int WIDTH     = 44,
    parameter int DEPTH     = 4,
    parameter int LOG_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     din,
    input  logic                 pop,
    output logic                 vld,
    output logic [WIDTH-1:0]     dout,
    output logic [LOG_DEPTH:0]   count,
    output logic                 full,
    output logic                 accepted
);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic                 do_pop;
    logic                 do_push;

    function automatic logic [LOG_DEPTH-1:0] ptr_inc(input logic [LOG_DEPTH-1:0] p);
        return (p == LOG_DEPTH'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign vld      = (count != '0);
    assign full     = (count == (LOG_DEPTH+1)'(DEPTH));
    assign do_pop   = pop && vld;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign accepted = do_push;
    assign dout     = vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/sw_score_collector.sv
// Sink for the systolic PE chain: tracks the best score per valid window, tags it
// with id/length/hit and queues it into a small FWFT result FIFO.
module sw_score_collector #(
    parameter int SCORE_WIDTH = 11,
    parameter int LEN_WIDTH   = 16,
    parameter int ID_WIDTH    = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int LOG_DEPTH   = 2
) (
    input  logic                          clk,
    input  logic                          i_rst,
    input  logic                          i_vld,
    input  logic [SCORE_WIDTH-1:0]        i_high,
    input  logic [SCORE_WIDTH-1:0]        i_threshold,
    input  logic                          i_res_rdy,
    output logic                          o_res_vld,
    output logic signed [SCORE_WIDTH-1:0] o_res_score,
    output logic [LEN_WIDTH-1:0]          o_res_len,
    output logic [ID_WIDTH-1:0]           o_res_id,
    output logic                          o_res_hit,
    output logic                          o_overflow,
    output logic                          o_busy,
    output logic [LOG_DEPTH:0]            o_count
);

    import sw_pkg::*;

    localparam int REC_W = ID_WIDTH + SCORE_WIDTH + LEN_WIDTH + 1;

    coll_state_t                   state;
    coll_state_t                   state_nxt;
    logic [SCORE_WIDTH-1:0]        run_max;
    logic [LEN_WIDTH-1:0]          len;
    logic [ID_WIDTH-1:0]           next_id;
    logic                          start_win;
    logic                          extend_win;
    logic signed [SCORE_WIDTH-1:0] commit_score;
    logic                          commit_hit;
    logic                          push;
    logic                          accepted;
    logic                          fifo_full;
    logic [REC_W-1:0]              push_rec;
    logic [REC_W-1:0]              head_rec;

    function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_vld) state_nxt = ACCUM;
            ACCUM:   if (!i_vld) state_nxt = COMMIT;
            COMMIT:  state_nxt = i_vld ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Any valid outside ACCUM opens a fresh window; the COMMIT cycle can do both.
    assign start_win  = i_vld && (state != ACCUM);
    assign extend_win = i_vld && (state == ACCUM);

    assign commit_score = to_signed_score(run_max);
    assign commit_hit   = (commit_score >= $signed(i_threshold));
    assign push         = (state == COMMIT);
    assign push_rec     = {next_id, commit_score, len, commit_hit};

    always_ff @(posedge clk) begin
        if (i_rst) begin
            run_max    <= NEUTRAL_SCORE;
            len        <= '0;
            next_id    <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (start_win) begin
                run_max <= i_high;
                len     <= LEN_WIDTH'(1);
            end else if (extend_win) begin
                if (i_high > run_max) begin
                    run_max <= i_high;
                end
                len <= sat_inc(len);
            end
            if (push) begin
                next_id <= next_id + 1'b1;
                if (!accepted) begin
                    o_overflow <= 1'b1;
                end
            end
        end
    end

    sw_result_fifo #(
        .WIDTH     (REC_W),
        .DEPTH     (FIFO_DEPTH),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .i_rst    (i_rst),
        .push     (push),
        .din      (push_rec),
        .pop      (i_res_rdy),
        .vld      (o_res_vld),
        .dout     (head_rec),
        .count    (o_count),
        .full     (fifo_full),
        .accepted (accepted)
    );

    assign {o_res_id, o_res_score, o_res_len, o_res_hit} = head_rec;
    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_sw_score_collector.sv
// Scoreboard bench for sw_score_collector: directed windows plus randomized traffic
// checked against a window-level reference model.
module tb_sw_score_collector;

    logic               clk = 1'b0;
    logic               i_rst;
    logic               i_vld;
    logic [10:0]        i_high;
    logic [10:0]        i_threshold;
    logic               i_res_rdy;
    logic               o_res_vld;
    logic signed [10:0] o_res_score;
    logic [15:0]        o_res_len;
    logic [15:0]        o_res_id;
    logic               o_res_hit;
    logic               o_overflow;
    logic               o_busy;
    logic [2:0]         o_count;

    always #5 clk = ~clk;

    sw_score_collector dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_vld       (i_vld),
        .i_high      (i_high),
        .i_threshold (i_threshold),
        .i_res_rdy   (i_res_rdy),
        .o_res_vld   (o_res_vld),
        .o_res_score (o_res_score),
        .o_res_len   (o_res_len),
        .o_res_id    (o_res_id),
        .o_res_hit   (o_res_hit),
        .o_overflow  (o_overflow),
        .o_busy      (o_busy),
        .o_count     (o_count)
    );

    typedef struct {
        int id;
        int score;
        int len;
        bit hit;
    } exp_t;

    exp_t q[$];
    int   win_highs[$];
    bit   m_in_win;
    bit   m_commit;
    bit   m_ovf;
    int   m_next_id;
    int   compared   = 0;
    int   mismatched = 0;
    bit   rnd_rdy    = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        win_highs.delete();
        m_in_win  = 1'b0;
        m_commit  = 1'b0;
        m_ovf     = 1'b0;
        m_next_id = 0;
    endfunction

    // Monitor + reference model; inputs are stable here for the coming edge.
    always @(negedge clk) begin
        bit   pop;
        exp_t r;
        int   mx;
        if (i_rst) begin
            model_reset();
        end else begin
            chk("res_vld", longint'(o_res_vld), longint'(q.size() != 0));
            chk("count", longint'(o_count), longint'(q.size()));
            chk("overflow", longint'(o_overflow), longint'(m_ovf));
            chk("busy", longint'(o_busy), longint'(m_in_win || m_commit));
            if (q.size() != 0) begin
                chk("head_id", longint'(o_res_id), longint'(q[0].id));
                chk("head_score", longint'(o_res_score), longint'(q[0].score));
                chk("head_len", longint'(o_res_len), longint'(q[0].len));
                chk("head_hit", longint'(o_res_hit), longint'(q[0].hit));
            end else begin
                chk("idle_head", longint'({o_res_id, o_res_score, o_res_len, o_res_hit}), 0);
            end
            pop = (q.size() != 0) && i_res_rdy;
            if (pop) void'(q.pop_front());

            if (m_commit) begin
                mx = 0;
                foreach (win_highs[i]) if (win_highs[i] > mx) mx = win_highs[i];
                r.id    = m_next_id;
                r.score = mx - 1024;
                r.len   = (win_highs.size() > 65535) ? 65535 : win_highs.size();
                r.hit   = (r.score >= int'($signed(i_threshold)));
                m_next_id = (m_next_id + 1) % 65536;
                if (q.size() < 4) q.push_back(r);
                else m_ovf = 1'b1;
                m_commit = 1'b0;
                win_highs.delete();
                if (i_vld) begin
                    m_in_win = 1'b1;
                    win_highs.push_back(int'(i_high));
                end
            end else if (m_in_win) begin
                if (i_vld) win_highs.push_back(int'(i_high));
                else begin
                    m_in_win = 1'b0;
                    m_commit = 1'b1;
                end
            end else if (i_vld) begin
                m_in_win = 1'b1;
                win_highs.push_back(int'(i_high));
            end
        end
    end

    task automatic drv(input bit v, input int h);
        @(posedge clk);
        #1;
        i_vld  = v;
        i_high = 11'(h);
        if (rnd_rdy) i_res_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 1024);
    endtask

    task automatic window(input int h[$]);
        foreach (h[i]) drv(1'b1, h[i]);
        drv(1'b0, 1024);
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #1;
        i_rst = 1'b1;
        i_vld = 1'b0;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    initial begin
        int hs[$];
        i_rst       = 1'b1;
        i_vld       = 1'b0;
        i_high      = 11'd1024;
        i_threshold = 11'd0;
        i_res_rdy   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", longint'(o_count), 0);
        chk("rst_busy0", longint'(o_busy), 0);
        i_rst = 1'b0;

        // Single window, then a miss and a negative-score hit.
        i_threshold = 11'd10;
        window('{1024, 1030, 1045, 1040, 1045});
        idle(4);
        window('{1020, 1027, 1000});
        idle(3);
        i_threshold = 11'(-8);
        window('{1020, 1020, 1020});
        idle(3);

        // Backpressure: six windows into a four-deep FIFO.
        i_res_rdy = 1'b0;
        repeat (6) begin
            window('{1030, 1100, 1050});
            idle(1);
        end
        idle(2);
        chk("bp_count", longint'(o_count), 4);
        chk("bp_overflow", longint'(o_overflow), 1);
        i_res_rdy = 1'b1;
        idle(6);
        window('{1060, 1061});
        idle(4);

        // Full FIFO with a pop exactly in the commit cycle.
        rst_pulse();
        i_res_rdy   = 1'b0;
        i_threshold = 11'd0;
        repeat (4) begin
            window('{1040, 1041});
            idle(1);
        end
        drv(1'b1, 1070);
        drv(1'b1, 1080);
        drv(1'b1, 1075);
        drv(1'b0, 1024);
        @(posedge clk);
        #1;
        i_res_rdy = 1'b1;
        @(posedge clk);
        #1;
        i_res_rdy = 1'b0;
        idle(2);
        chk("fullpop_count", longint'(o_count), 4);
        chk("fullpop_overflow", longint'(o_overflow), 0);
        i_res_rdy = 1'b1;
        idle(6);

        // Back-to-back windows separated by a single low cycle.
        window('{1040, 1050, 1033});
        window('{1030, 1010});
        idle(4);

        // Reset in the middle of a window.
        drv(1'b1, 1100);
        drv(1'b1, 1101);
        drv(1'b1, 1102);
        rst_pulse();
        chk("rst_mid_busy", longint'(o_busy), 0);
        window('{1034, 1020});
        idle(4);

        // Randomized traffic with random backpressure and thresholds.
        rnd_rdy = 1'b1;
        repeat (40) begin
            hs.delete();
            repeat ($urandom_range(1, 6)) hs.push_back(int'($urandom_range(900, 1200)));
            i_threshold = 11'(int'($urandom_range(0, 128)) - 64);
            window(hs);
            idle($urandom_range(0, 3));
        end
        rnd_rdy   = 1'b0;
        i_res_rdy = 1'b1;
        idle(10);
        chk("drained", longint'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
